// File: rtl/bcd_time_keeper_if.sv
// Signal bundle between the time keeper, its divider/button sources and the display driver.
// The master side drives slow_clk and the buttons; the slave side returns the BCD digits and strobes.
interface bcd_time_keeper_if;
    logic       slow_clk;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hr;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [3:0] hr_ones;
    logic [3:0] hr_tens;
    logic       sec_pulse;
    logic       day_pulse;

    modport master (
        output slow_clk, set_mode, inc_min, inc_hr,
        input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        input  sec_pulse, day_pulse
    );

    modport slave (
        input  slow_clk, set_mode, inc_min, inc_hr,
        output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        output sec_pulse, day_pulse
    );
endinterface

// File: rtl/bcd_time_keeper.sv
// 24-hour BCD time of day, advanced by rising edges of an asynchronous 1 Hz square wave,
// with a set mode that steps minutes and hours from debounced buttons.
module bcd_time_keeper #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_time_keeper_if.slave   bus
);
    localparam int unsigned LAST   = SYNC_STAGES - 1;
    localparam int unsigned PAIR_W = 8;

    logic [LAST:0]       sync_q;
    logic [LAST:0]       vld_q;
    logic                primed_q;
    logic                primed_n;
    logic                tick_n;
    logic                sec_pulse_q;
    logic                day_pulse_q;
    logic                day_pulse_n;
    logic                inc_min_q;
    logic                inc_hr_q;
    logic                min_edge;
    logic                hr_edge;
    logic [PAIR_W-1:0]   sec_q, sec_n;
    logic [PAIR_W-1:0]   min_q, min_n;
    logic [PAIR_W-1:0]   hr_q,  hr_n;

    // Two-digit BCD increment wrapping 59 -> 00.
    function automatic logic [PAIR_W-1:0] inc_base60(input logic [PAIR_W-1:0] v);
        logic [PAIR_W-1:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
        end
        return r;
    endfunction

    // Two-digit BCD increment wrapping 23 -> 00.
    function automatic logic [PAIR_W-1:0] inc_hours(input logic [PAIR_W-1:0] v);
        logic [PAIR_W-1:0] r;
        r = v;
        if (v == 8'h23) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // vld_q tracks which sync stages hold real samples, so reset zeros never prime the edge detector.
    // sec_pulse_q is itself the edge stage: it is loaded with the tick that the settled samples imply.
    assign primed_n = primed_q | (vld_q[LAST] & ~sync_q[LAST]);
    assign tick_n   = sync_q[LAST-1] & ~sync_q[LAST] & primed_n;
    assign min_edge = bus.inc_min & ~inc_min_q;
    assign hr_edge  = bus.inc_hr  & ~inc_hr_q;

    // Next time of day: set mode overrides ticks and never raises day_pulse.
    always_comb begin
        sec_n       = sec_q;
        min_n       = min_q;
        hr_n        = hr_q;
        day_pulse_n = 1'b0;
        if (bus.set_mode) begin
            sec_n = '0;
            if (min_edge) min_n = inc_base60(min_q);
            if (hr_edge)  hr_n  = inc_hours(hr_q);
        end else if (sec_pulse_q) begin
            sec_n = inc_base60(sec_q);
            if (sec_q == 8'h59) begin
                min_n = inc_base60(min_q);
                if (min_q == 8'h59) begin
                    hr_n        = inc_hours(hr_q);
                    day_pulse_n = (hr_q == 8'h23);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            vld_q       <= '0;
            primed_q    <= 1'b0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hr_q    <= 1'b0;
            sec_q       <= '0;
            min_q       <= '0;
            hr_q        <= '0;
        end else begin
            sync_q      <= {sync_q[LAST-1:0], bus.slow_clk};
            vld_q       <= {vld_q[LAST-1:0], 1'b1};
            primed_q    <= primed_n;
            sec_pulse_q <= tick_n;
            day_pulse_q <= day_pulse_n;
            inc_min_q   <= bus.inc_min;
            inc_hr_q    <= bus.inc_hr;
            sec_q       <= sec_n;
            min_q       <= min_n;
            hr_q        <= hr_n;
        end
    end

    assign bus.sec_ones  = sec_q[3:0];
    assign bus.sec_tens  = sec_q[7:4];
    assign bus.min_ones  = min_q[3:0];
    assign bus.min_tens  = min_q[7:4];
    assign bus.hr_ones   = hr_q[3:0];
    assign bus.hr_tens   = hr_q[7:4];
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_pulse = day_pulse_q;
endmodule
